// File: rtl/ama_riscv_fetch_queue.sv
// Instruction fetch front-end: issues word-address requests to the icache,
// tags responses with their pc and buffers them in a small FIFO for decode.
module ama_riscv_fetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CORE_WORD_ADDR_BUS = 30,
  parameter int unsigned INST_WIDTH = 32,
  parameter logic [CORE_WORD_ADDR_BUS-1:0] RESET_PC = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic                          req_ic_valid,
  input  logic                          req_ic_ready,
  output logic [CORE_WORD_ADDR_BUS-1:0] req_ic_data,
  input  logic                          rsp_ic_valid,
  input  logic [INST_WIDTH-1:0]         rsp_ic_data,
  output logic                          spec_wrong,
  input  logic                          redirect_valid,
  input  logic [CORE_WORD_ADDR_BUS-1:0] redirect_pc,
  output logic                          inst_valid,
  input  logic                          inst_ready,
  output logic [INST_WIDTH-1:0]         inst_data,
  output logic [CORE_WORD_ADDR_BUS-1:0] inst_pc
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("ama_riscv_fetch_queue: DEPTH must be a power of 2 and at least 2");
  end

  logic [CORE_WORD_ADDR_BUS-1:0] fetch_pc;
  logic [CORE_WORD_ADDR_BUS-1:0] outstanding_pc;
  logic                          outstanding;
  logic [PTR_W-1:0]              rd_ptr;
  logic [PTR_W-1:0]              wr_ptr;
  logic [CNT_W-1:0]              count;
  logic [CNT_W-1:0]              occupancy;
  logic [CORE_WORD_ADDR_BUS-1:0] mem_pc [DEPTH];
  logic [INST_WIDTH-1:0]         mem_inst [DEPTH];
  logic                          acc;
  logic                          push;
  logic                          pop;

  // The in-flight request reserves a slot; pops in the same cycle are not credited.
  assign occupancy = count + CNT_W'(outstanding);

  always_comb begin
    req_ic_valid = 1'b0;
    req_ic_data  = '0;
    spec_wrong   = 1'b0;
    if (!rst) begin
      req_ic_valid = redirect_valid ||
                     ((!outstanding || rsp_ic_valid) && (occupancy < DEPTH_CNT));
      req_ic_data  = redirect_valid ? redirect_pc : fetch_pc;
      spec_wrong   = redirect_valid && outstanding && !rsp_ic_valid;
    end
  end

  assign acc        = req_ic_valid && (req_ic_ready || spec_wrong);
  assign push       = rsp_ic_valid && outstanding && !redirect_valid;
  assign inst_valid = (count != '0);
  assign pop        = inst_valid && inst_ready;
  assign inst_data  = inst_valid ? mem_inst[rd_ptr] : '0;
  assign inst_pc    = inst_valid ? mem_pc[rd_ptr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      outstanding <= 1'b0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      if (acc) begin
        outstanding <= 1'b1;
        fetch_pc    <= req_ic_data + CORE_WORD_ADDR_BUS'(1);
      end else if (redirect_valid) begin
        outstanding <= 1'b0;
        fetch_pc    <= redirect_pc;
      end else if (push) begin
        outstanding <= 1'b0;
      end

      // A redirect flushes the queue and drops any coincident response.
      if (redirect_valid) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        if (push && !pop)      count <= count + CNT_W'(1);
        else if (pop && !push) count <= count - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (acc) outstanding_pc <= req_ic_data;
    if (push) begin
      mem_pc[wr_ptr]   <= outstanding_pc;
      mem_inst[wr_ptr] <= rsp_ic_data;
    end
  end

endmodule

// File: tb/tb_ama_riscv_fetch_queue.sv
// Bench for ama_riscv_fetch_queue: queue-based reference model, a simple
// icache responder and directed scenarios with literal expectations.
module tb_ama_riscv_fetch_queue;
  localparam int DEPTH = 4;
  localparam int AW = 16;
  localparam int IW = 32;
  localparam logic [AW-1:0] RST_PC = 16'h0040;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_ic_valid;
  logic          req_ic_ready = 1'b0;
  logic [AW-1:0] req_ic_data;
  logic          rsp_ic_valid = 1'b0;
  logic [IW-1:0] rsp_ic_data = '0;
  logic          spec_wrong;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          inst_valid;
  logic          inst_ready = 1'b0;
  logic [IW-1:0] inst_data;
  logic [AW-1:0] inst_pc;

  ama_riscv_fetch_queue #(
    .DEPTH(DEPTH), .CORE_WORD_ADDR_BUS(AW), .INST_WIDTH(IW), .RESET_PC(RST_PC)
  ) dut (
    .clk(clk), .rst(rst),
    .req_ic_valid(req_ic_valid), .req_ic_ready(req_ic_ready), .req_ic_data(req_ic_data),
    .rsp_ic_valid(rsp_ic_valid), .rsp_ic_data(rsp_ic_data), .spec_wrong(spec_wrong),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 'h%0h, want 'h%0h", name, act, exp);
    end
  endtask

  function automatic logic [IW-1:0] inst_of(input logic [AW-1:0] pc);
    return {pc ^ 16'h5A5A, ~pc};
  endfunction

  // Reference model: queue of {pc, inst}, fetch pointer and one in-flight tag
  logic [AW+IW-1:0] m_q[$];
  logic [AW-1:0]    m_fetch = RST_PC;
  logic             m_out = 1'b0;
  logic [AW-1:0]    m_out_pc = '0;

  // icache responder state; latency counted from accept
  logic          ic_busy = 1'b0;
  logic [AW-1:0] ic_addr = '0;
  int            ic_wait = 0;
  int            miss_lat = 0;
  logic          ic_rsp_next = 1'b0;

  logic [AW-1:0] got[$];

  always @(negedge clk) begin : compare
    logic e_rv, e_sw, e_iv, acc;
    logic [AW-1:0] e_rd;
    if (rst) begin
      check("rst_req_valid", req_ic_valid, 0);
      check("rst_req_data", req_ic_data, 0);
      check("rst_spec_wrong", spec_wrong, 0);
      check("rst_inst_valid", inst_valid, 0);
      check("rst_inst_data", inst_data, 0);
      check("rst_inst_pc", inst_pc, 0);
      m_q.delete();
      m_fetch = RST_PC;
      m_out = 1'b0;
      ic_busy = 1'b0;
      ic_wait = 0;
      ic_rsp_next = 1'b0;
    end else begin
      e_rv = redirect_valid || ((!m_out || rsp_ic_valid) && (m_q.size() + int'(m_out) < DEPTH));
      e_rd = redirect_valid ? redirect_pc : m_fetch;
      e_sw = redirect_valid && m_out && !rsp_ic_valid;
      e_iv = (m_q.size() != 0);
      check("req_valid", req_ic_valid, e_rv);
      check("spec_wrong", spec_wrong, e_sw);
      check("inst_valid", inst_valid, e_iv);
      if (e_rv) check("req_data", req_ic_data, e_rd);
      if (e_iv) begin
        check("inst_pc", inst_pc, m_q[0][AW+IW-1:IW]);
        check("inst_data", inst_data, m_q[0][IW-1:0]);
      end
      if (inst_valid && inst_ready) got.push_back(inst_pc);

      acc = e_rv && (req_ic_ready || e_sw);
      if (redirect_valid) m_q.delete();
      else begin
        if (e_iv && inst_ready) void'(m_q.pop_front());
        if (rsp_ic_valid && m_out) m_q.push_back({m_out_pc, rsp_ic_data});
      end
      if (acc) begin
        m_out = 1'b1;
        m_out_pc = e_rd;
        m_fetch = e_rd + 16'd1;
      end else if (redirect_valid) begin
        m_out = 1'b0;
        m_fetch = redirect_pc;
      end else if (rsp_ic_valid && m_out) begin
        m_out = 1'b0;
      end

      if (rsp_ic_valid || spec_wrong) ic_busy = 1'b0;
      if (req_ic_valid && (req_ic_ready || spec_wrong)) begin
        ic_busy = 1'b1;
        ic_addr = req_ic_data;
        ic_wait = miss_lat;
      end else if (ic_busy && ic_wait > 0) begin
        ic_wait--;
      end
      ic_rsp_next = ic_busy && (ic_wait == 0);
    end
  end

  initial begin : icache_drive
    forever begin
      @(posedge clk);
      #1;
      rsp_ic_valid = ic_rsp_next;
      rsp_ic_data  = ic_rsp_next ? inst_of(ic_addr) : '0;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [AW-1:0] got_at(input int i);
    return (i < got.size()) ? got[i] : 16'hDEAD;
  endfunction

  initial begin : stimulus
    bit ok;
    int n0;
    tick(2);
    #1;
    check("reset_req_valid_lit", req_ic_valid, 0);
    check("reset_inst_valid_lit", inst_valid, 0);

    // Hit stream from RESET_PC, one instruction per cycle
    tick(1);
    rst = 1'b0;
    req_ic_ready = 1'b1;
    inst_ready = 1'b1;
    #1;
    check("first_req_valid", req_ic_valid, 1);
    check("first_req_pc", req_ic_data, 16'h0040);
    tick(12);
    check("hit_throughput", got.size(), 10);
    check("hit_pc0", got_at(0), 16'h0040);
    check("hit_pc1", got_at(1), 16'h0041);
    check("hit_pc2", got_at(2), 16'h0042);

    // Backpressure: queue fills to DEPTH, fetch stops, then drains exactly DEPTH
    inst_ready = 1'b0;
    tick(10);
    check("bp_req_stopped", req_ic_valid, 0);
    check("bp_head_valid", inst_valid, 1);
    req_ic_ready = 1'b0;
    inst_ready = 1'b1;
    n0 = got.size();
    tick(8);
    check("bp_drained", got.size() - n0, DEPTH);
    req_ic_ready = 1'b1;
    tick(6);
    ok = 1'b1;
    for (int i = 0; i < got.size(); i++) if (got[i] !== RST_PC + 16'(i)) ok = 1'b0;
    check("bp_stream_order", ok, 1);

    // Miss: request at 'h80 accepted, icache stalls the next request
    redirect_valid = 1'b1;
    redirect_pc = 16'h0080;
    tick(1);
    redirect_valid = 1'b0;
    req_ic_ready = 1'b0;
    got.delete();
    for (int i = 0; i < 10; i++) begin
      #1;
      check("miss_hold_valid", req_ic_valid, 1);
      check("miss_hold_pc", req_ic_data, 16'h0081);
      tick(1);
    end
    req_ic_ready = 1'b1;
    tick(4);
    check("miss_pc0", got_at(0), 16'h0080);
    check("miss_pc1", got_at(1), 16'h0081);

    // Redirect while 'h80 is still unanswered
    miss_lat = 20;
    redirect_valid = 1'b1;
    redirect_pc = 16'h0080;
    tick(1);
    redirect_valid = 1'b0;
    tick(3);
    got.delete();
    miss_lat = 0;
    redirect_valid = 1'b1;
    redirect_pc = 16'h0200;
    #1;
    check("kill_spec_wrong", spec_wrong, 1);
    check("kill_req_pc", req_ic_data, 16'h0200);
    tick(1);
    redirect_valid = 1'b0;
    #1;
    check("kill_spec_wrong_off", spec_wrong, 0);
    check("kill_fifo_empty", inst_valid, 0);
    tick(5);
    check("kill_pc0", got_at(0), 16'h0200);
    ok = 1'b1;
    foreach (got[i]) if (got[i] == 16'h0080) ok = 1'b0;
    check("kill_no_stale", ok, 1);

    // Redirect coincident with a response
    redirect_valid = 1'b1;
    redirect_pc = 16'h0300;
    #1;
    check("coinc_rsp_present", rsp_ic_valid, 1);
    check("coinc_spec_wrong", spec_wrong, 0);
    tick(1);
    redirect_valid = 1'b0;
    got.delete();
    #1;
    check("coinc_fifo_empty", inst_valid, 0);
    tick(4);
    check("coinc_pc0", got_at(0), 16'h0300);

    // Address wrap at the top of the word address space
    redirect_valid = 1'b1;
    redirect_pc = 16'hFFFE;
    tick(1);
    redirect_valid = 1'b0;
    got.delete();
    tick(6);
    check("wrap_pc0", got_at(0), 16'hFFFE);
    check("wrap_pc1", got_at(1), 16'hFFFF);
    check("wrap_pc2", got_at(2), 16'h0000);
    check("wrap_pc3", got_at(3), 16'h0001);

    // Back-to-back redirects: only the second one steers fetch
    redirect_valid = 1'b1;
    redirect_pc = 16'h0500;
    tick(1);
    redirect_pc = 16'h0600;
    tick(1);
    redirect_valid = 1'b0;
    got.delete();
    tick(5);
    check("b2b_pc0", got_at(0), 16'h0600);
    ok = 1'b1;
    foreach (got[i]) if (got[i][15:8] == 8'h05) ok = 1'b0;
    check("b2b_no_first", ok, 1);

    // Asynchronous reset pulse between clock edges
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_req_valid", req_ic_valid, 0);
    check("arst_req_data", req_ic_data, 0);
    check("arst_spec_wrong", spec_wrong, 0);
    check("arst_inst_valid", inst_valid, 0);
    check("arst_inst_pc", inst_pc, 0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("arst_first_valid", req_ic_valid, 1);
    check("arst_first_pc", req_ic_data, 16'h0040);
    got.delete();
    tick(5);
    check("arst_pc0", got_at(0), 16'h0040);

    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "bench timeout");
  end

endmodule
